// File: rtl/harbinger_pkg.sv
// Shared synth constants and type definitions for the harbinger voice engine.
// Holds the voice allocator FSM encoding and default widths.
package harbinger_pkg;

   localparam int NVOICE_DEFAULT     = 8;
   localparam int NOTE_W_DEFAULT     = 7;
   localparam int AGE_W_DEFAULT      = 8;
   localparam int REL_CYCLES_DEFAULT = 24000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      APPLY = 2'd2
   } alloc_state_e;

endpackage

// File: rtl/voice_slot.sv
// One polyphonic voice: gate, assigned note, age and release countdown.
// A note-on load wins over a note-off, a release decrement and an age increment.
module voice_slot
   import harbinger_pkg::*;
#(
   parameter int NOTE_W     = NOTE_W_DEFAULT,
   parameter int AGE_W      = AGE_W_DEFAULT,
   parameter int REL_CYCLES = REL_CYCLES_DEFAULT
) (
   input  logic              clk24,
   input  logic              rst,
   input  logic              on_load,
   input  logic              off_load,
   input  logic              age_inc,
   input  logic [NOTE_W-1:0] note_in,
   output logic              gate,
   output logic [NOTE_W-1:0] note,
   output logic [AGE_W-1:0]  age,
   output logic              busy,
   output logic              releasing
);

   localparam int REL_W = $clog2(REL_CYCLES + 1);
   localparam logic [REL_W-1:0] REL_LOAD = REL_W'(REL_CYCLES);
   localparam logic [AGE_W-1:0] AGE_MAX  = '1;

   logic [REL_W-1:0] rel_cnt;

   always_ff @(posedge clk24) begin
      if (rst) begin
         gate    <= 1'b0;
         note    <= '0;
         age     <= '0;
         rel_cnt <= '0;
      end else if (on_load) begin
         gate    <= 1'b1;
         note    <= note_in;
         age     <= '0;
         rel_cnt <= '0;
      end else begin
         if (off_load) begin
            gate    <= 1'b0;
            rel_cnt <= REL_LOAD;
         end else if (rel_cnt != '0) begin
            rel_cnt <= rel_cnt - 1'b1;
         end
         if (age_inc && (age != AGE_MAX)) begin
            age <= age + 1'b1;
         end
      end
   end

   assign busy      = gate | (rel_cnt != '0);
   assign releasing = ~gate & (rel_cnt != '0);

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: accepts note events, scans every voice once,
// then applies the note-on/note-off to the chosen voice in a single cycle.
module voice_alloc
   import harbinger_pkg::*;
#(
   parameter int NVOICE     = NVOICE_DEFAULT,
   parameter int NOTE_W     = NOTE_W_DEFAULT,
   parameter int REL_CYCLES = REL_CYCLES_DEFAULT,
   parameter int AGE_W      = AGE_W_DEFAULT
) (
   input  logic                     clk24,
   input  logic                     rst,
   input  logic                     ev_valid,
   output logic                     ev_ready,
   input  logic                     ev_on,
   input  logic [NOTE_W-1:0]        ev_note,
   output logic [NVOICE-1:0]        voice_trig,
   output logic [NVOICE-1:0]        voice_gate,
   output logic [NVOICE*NOTE_W-1:0] voice_note,
   output logic [NVOICE-1:0]        voice_busy,
   output logic                     steal
);

   localparam int IDX_W = $clog2(NVOICE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVOICE - 1);

   alloc_state_e state, state_next;

   logic              ev_on_q;
   logic [NOTE_W-1:0] ev_note_q;
   logic [IDX_W-1:0]  scan_idx;

   logic              match_found, free_found, rel_found, old_found;
   logic [IDX_W-1:0]  match_idx, free_idx, rel_idx, old_idx;
   logic [AGE_W-1:0]  old_age;

   logic [NVOICE-1:0] slot_gate, slot_busy, slot_rel;
   logic [NVOICE-1:0] on_load, off_load, age_inc;
   logic [NOTE_W-1:0] slot_note [NVOICE];
   logic [AGE_W-1:0]  slot_age  [NVOICE];

   logic              cur_gate, cur_busy, cur_rel;
   logic [NOTE_W-1:0] cur_note;
   logic [AGE_W-1:0]  cur_age;

   logic              accept;
   logic              do_on, do_off, stealing;
   logic [IDX_W-1:0]  target;

   assign accept = ev_valid & ev_ready;

   always_ff @(posedge clk24) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SCAN;
         SCAN:    if (scan_idx == LAST_IDX) state_next = APPLY;
         APPLY:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign cur_gate = slot_gate[scan_idx];
   assign cur_busy = slot_busy[scan_idx];
   assign cur_rel  = slot_rel[scan_idx];
   assign cur_note = slot_note[scan_idx];
   assign cur_age  = slot_age[scan_idx];

   // Candidates keep the first hit in index order; the oldest only moves on a
   // strictly greater age so ties resolve to the lowest index.
   always_ff @(posedge clk24) begin
      if (rst) begin
         ev_ready    <= 1'b0;
         ev_on_q     <= 1'b0;
         ev_note_q   <= '0;
         scan_idx    <= '0;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         rel_found   <= 1'b0;
         old_found   <= 1'b0;
         match_idx   <= '0;
         free_idx    <= '0;
         rel_idx     <= '0;
         old_idx     <= '0;
         old_age     <= '0;
      end else begin
         ev_ready <= (state_next == IDLE);
         case (state)
            IDLE: begin
               if (accept) begin
                  ev_on_q     <= ev_on;
                  ev_note_q   <= ev_note;
                  scan_idx    <= '0;
                  match_found <= 1'b0;
                  free_found  <= 1'b0;
                  rel_found   <= 1'b0;
                  old_found   <= 1'b0;
               end
            end
            SCAN: begin
               if (scan_idx != LAST_IDX) scan_idx <= scan_idx + 1'b1;
               if (!match_found && cur_gate && (cur_note == ev_note_q)) begin
                  match_found <= 1'b1;
                  match_idx   <= scan_idx;
               end
               if (!free_found && !cur_busy) begin
                  free_found <= 1'b1;
                  free_idx   <= scan_idx;
               end
               if (!rel_found && cur_rel) begin
                  rel_found <= 1'b1;
                  rel_idx   <= scan_idx;
               end
               if (cur_gate && (!old_found || (cur_age > old_age))) begin
                  old_found <= 1'b1;
                  old_idx   <= scan_idx;
                  old_age   <= cur_age;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      target   = '0;
      do_on    = 1'b0;
      do_off   = 1'b0;
      stealing = 1'b0;
      if (state == APPLY) begin
         if (ev_on_q) begin
            do_on = 1'b1;
            if (match_found) begin
               target = match_idx;
            end else if (free_found) begin
               target = free_idx;
            end else if (rel_found) begin
               target = rel_idx;
            end else if (old_found) begin
               target   = old_idx;
               stealing = 1'b1;
            end else begin
               do_on = 1'b0;
            end
         end else if (match_found) begin
            do_off = 1'b1;
            target = match_idx;
         end
      end
   end

   for (genvar i = 0; i < NVOICE; i++) begin : g_slot
      assign on_load[i]  = do_on  && (target == IDX_W'(i));
      assign off_load[i] = do_off && (target == IDX_W'(i));
      assign age_inc[i]  = do_on  && slot_gate[i] && (target != IDX_W'(i));

      voice_slot #(
         .NOTE_W     (NOTE_W),
         .AGE_W      (AGE_W),
         .REL_CYCLES (REL_CYCLES)
      ) u_slot (
         .clk24     (clk24),
         .rst       (rst),
         .on_load   (on_load[i]),
         .off_load  (off_load[i]),
         .age_inc   (age_inc[i]),
         .note_in   (ev_note_q),
         .gate      (slot_gate[i]),
         .note      (slot_note[i]),
         .age       (slot_age[i]),
         .busy      (slot_busy[i]),
         .releasing (slot_rel[i])
      );

      assign voice_note[i*NOTE_W +: NOTE_W] = slot_note[i];
   end

   assign voice_trig = on_load;
   assign voice_gate = slot_gate;
   assign voice_busy = slot_busy;
   assign steal      = stealing;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc with 8 voices and a 16-cycle release hold.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_voice_alloc;

   localparam int NV   = 8;
   localparam int NW   = 7;
   localparam int RELC = 16;

   logic            clk24 = 1'b0;
   logic            rst   = 1'b1;
   logic            ev_valid = 1'b0;
   logic            ev_ready;
   logic            ev_on = 1'b0;
   logic [NW-1:0]   ev_note = '0;
   logic [NV-1:0]   voice_trig;
   logic [NV-1:0]   voice_gate;
   logic [NV*NW-1:0] voice_note;
   logic [NV-1:0]   voice_busy;
   logic            steal;

   int checks = 0;
   int errors = 0;

   int            low_cycles, trig_cycles, steal_cycles;
   logic [NV-1:0] trig_seen;

   voice_alloc #(
      .NVOICE     (NV),
      .NOTE_W     (NW),
      .REL_CYCLES (RELC),
      .AGE_W      (8)
   ) dut (
      .clk24      (clk24),
      .rst        (rst),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_on      (ev_on),
      .ev_note    (ev_note),
      .voice_trig (voice_trig),
      .voice_gate (voice_gate),
      .voice_note (voice_note),
      .voice_busy (voice_busy),
      .steal      (steal)
   );

   always #5 clk24 = ~clk24;

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [NW-1:0] note_of(input int i);
      return voice_note[i*NW +: NW];
   endfunction

   task automatic do_reset();
      @(negedge clk24);
      rst = 1'b1;
      ev_valid = 1'b0;
      repeat (3) @(negedge clk24);
      rst = 1'b0;
      @(negedge clk24);
   endtask

   // Offers one event at a falling edge and follows it until ev_ready returns.
   task automatic send_event(input logic on, input logic [NW-1:0] note);
      int guard;
      guard = 0;
      while (!ev_ready && guard < 50) begin
         @(negedge clk24);
         guard++;
      end
      if (!ev_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_wait ev_ready=%b required 1", ev_ready);
      end
      ev_valid = 1'b1;
      ev_on    = on;
      ev_note  = note;
      @(posedge clk24);
      #1 ev_valid = 1'b0;
      low_cycles   = 0;
      trig_cycles  = 0;
      steal_cycles = 0;
      trig_seen    = '0;
      guard        = 0;
      @(negedge clk24);
      while (!ev_ready && guard < 40) begin
         low_cycles++;
         trig_seen |= voice_trig;
         if (voice_trig != '0) trig_cycles++;
         if (steal) steal_cycles++;
         @(negedge clk24);
         guard++;
      end
      if (voice_trig != '0) trig_cycles++;
      if (steal) steal_cycles++;
   endtask

   task automatic test_reset();
      @(negedge clk24);
      checks++;
      if ({ev_ready, voice_trig, voice_gate, voice_busy, steal} !== '0 || voice_note !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state ready=%b trig=%h gate=%h busy=%h steal=%b note=%h required all 0",
                  ev_ready, voice_trig, voice_gate, voice_busy, steal, voice_note);
      end
      rst = 1'b0;
      @(negedge clk24);
      checks++;
      if (ev_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready ev_ready=%b required 1", ev_ready);
      end
   endtask

   task automatic test_single_note();
      do_reset();
      send_event(1'b1, 7'd60);
      checks++;
      if (low_cycles !== 9) begin
         errors++;
         $display("[TB] FAIL ready_low_cycles got %0d required 9", low_cycles);
      end
      checks++;
      if (trig_seen !== 8'h01 || trig_cycles !== 1) begin
         errors++;
         $display("[TB] FAIL single_trig trig=%h cycles=%0d required 01 / 1", trig_seen, trig_cycles);
      end
      checks++;
      if (voice_gate !== 8'h01 || note_of(0) !== 7'd60 || voice_busy !== 8'h01) begin
         errors++;
         $display("[TB] FAIL single_state gate=%h note0=%0d busy=%h required 01 / 60 / 01",
                  voice_gate, note_of(0), voice_busy);
      end
   endtask

   task automatic test_retrigger();
      do_reset();
      send_event(1'b1, 7'd60);
      send_event(1'b1, 7'd62);
      send_event(1'b1, 7'd64);
      checks++;
      if (voice_gate !== 8'h07 || note_of(1) !== 7'd62 || note_of(2) !== 7'd64) begin
         errors++;
         $display("[TB] FAIL three_notes gate=%h n1=%0d n2=%0d required 07 / 62 / 64",
                  voice_gate, note_of(1), note_of(2));
      end
      send_event(1'b1, 7'd62);
      checks++;
      if (trig_seen !== 8'h02 || voice_gate !== 8'h07 || steal_cycles !== 0) begin
         errors++;
         $display("[TB] FAIL retrigger trig=%h gate=%h steal=%0d required 02 / 07 / 0",
                  trig_seen, voice_gate, steal_cycles);
      end
   endtask

   task automatic test_release();
      int            cnt;
      logic [NV-1:0] g, b;
      logic [NV*NW-1:0] n;
      do_reset();
      send_event(1'b1, 7'd60);
      send_event(1'b0, 7'd60);
      checks++;
      if (voice_gate[0] !== 1'b0 || voice_busy[0] !== 1'b1 || trig_seen !== '0) begin
         errors++;
         $display("[TB] FAIL note_off gate0=%b busy0=%b trig=%h required 0 / 1 / 00",
                  voice_gate[0], voice_busy[0], trig_seen);
      end
      cnt = 0;
      while (voice_busy[0] && cnt < 100) begin
         cnt++;
         @(negedge clk24);
      end
      checks++;
      if (cnt !== RELC) begin
         errors++;
         $display("[TB] FAIL release_length busy cycles=%0d required %0d", cnt, RELC);
      end
      checks++;
      if (note_of(0) !== 7'd60) begin
         errors++;
         $display("[TB] FAIL release_note note0=%0d required 60", note_of(0));
      end
      send_event(1'b1, 7'd65);
      send_event(1'b1, 7'd66);
      checks++;
      if (voice_gate !== 8'h03 || note_of(0) !== 7'd65 || note_of(1) !== 7'd66) begin
         errors++;
         $display("[TB] FAIL reuse_free gate=%h n0=%0d n1=%0d required 03 / 65 / 66",
                  voice_gate, note_of(0), note_of(1));
      end
      g = voice_gate;
      b = voice_busy;
      n = voice_note;
      send_event(1'b0, 7'd70);
      checks++;
      if (low_cycles !== 9 || trig_seen !== '0 || voice_gate !== g || voice_busy !== b || voice_note !== n) begin
         errors++;
         $display("[TB] FAIL off_no_match low=%0d trig=%h gate=%h busy=%h required 9 / 00 / %h / %h",
                  low_cycles, trig_seen, voice_gate, voice_busy, g, b);
      end
   endtask

   task automatic test_steal();
      do_reset();
      for (int i = 0; i < 8; i++) send_event(1'b1, 7'(40 + i));
      checks++;
      if (voice_gate !== 8'hFF || note_of(7) !== 7'd47 || steal_cycles !== 0) begin
         errors++;
         $display("[TB] FAIL fill_all gate=%h n7=%0d steal=%0d required FF / 47 / 0",
                  voice_gate, note_of(7), steal_cycles);
      end
      send_event(1'b1, 7'd48);
      checks++;
      if (trig_seen !== 8'h01 || steal_cycles !== 1) begin
         errors++;
         $display("[TB] FAIL steal_oldest trig=%h steal=%0d required 01 / 1", trig_seen, steal_cycles);
      end
      checks++;
      if (note_of(0) !== 7'd48 || note_of(1) !== 7'd41 || voice_gate !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL steal_notes n0=%0d n1=%0d gate=%h required 48 / 41 / FF",
                  note_of(0), note_of(1), voice_gate);
      end
   endtask

   task automatic test_release_priority();
      do_reset();
      for (int i = 0; i < 8; i++) send_event(1'b1, 7'(40 + i));
      send_event(1'b0, 7'd43);
      checks++;
      if (voice_gate !== 8'hF7 || voice_busy !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL releasing_setup gate=%h busy=%h required F7 / FF", voice_gate, voice_busy);
      end
      send_event(1'b1, 7'd50);
      checks++;
      if (trig_seen !== 8'h08 || steal_cycles !== 0 || note_of(3) !== 7'd50 || voice_gate !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL release_target trig=%h steal=%0d n3=%0d gate=%h required 08 / 0 / 50 / FF",
                  trig_seen, steal_cycles, note_of(3), voice_gate);
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [NV-1:0] trig_or;
      do_reset();
      send_event(1'b1, 7'd60);
      ev_valid = 1'b1;
      ev_on    = 1'b1;
      ev_note  = 7'd62;
      @(posedge clk24);
      #1 ev_valid = 1'b0;
      trig_or = '0;
      repeat (4) begin
         @(negedge clk24);
         trig_or |= voice_trig;
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk24);
         trig_or |= voice_trig;
      end
      checks++;
      if ({ev_ready, voice_trig, voice_gate, voice_busy, steal} !== '0 || voice_note !== '0) begin
         errors++;
         $display("[TB] FAIL mid_scan_reset ready=%b trig=%h gate=%h busy=%h steal=%b required all 0",
                  ev_ready, voice_trig, voice_gate, voice_busy, steal);
      end
      rst = 1'b0;
      @(negedge clk24);
      trig_or |= voice_trig;
      checks++;
      if (ev_ready !== 1'b1 || trig_or !== '0) begin
         errors++;
         $display("[TB] FAIL mid_scan_recover ready=%b trig_seen=%h required 1 / 00", ev_ready, trig_or);
      end
      send_event(1'b1, 7'd33);
      checks++;
      if (trig_seen !== 8'h01 || note_of(0) !== 7'd33 || voice_gate !== 8'h01) begin
         errors++;
         $display("[TB] FAIL after_abort trig=%h n0=%0d gate=%h required 01 / 33 / 01",
                  trig_seen, note_of(0), voice_gate);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk24);
      test_reset();
      test_single_note();
      test_retrigger();
      test_release();
      test_steal();
      test_release_priority();
      test_reset_mid_scan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 SHALL have parameter NVOICE, default 8: number of voices managed, 2..16.
REQ-002 SHALL have parameter NOTE_W, default 7: note-number width.
REQ-003 SHALL have parameter REL_CYCLES, default 24000: release hold time in clk24 cycles, minimum 1.
REQ-004 SHALL have parameter AGE_W, default 8: per-voice age counter width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk24, input, 1 bit: the sole clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port ev_valid, input, 1 bit: note event offered.
REQ-009 SHALL have port ev_ready, output, 1 bit, registered: event accepted when ev_valid and ev_ready are both high at a rising edge.
REQ-010 SHALL have port ev_on, input, 1 bit: 1 = note-on, 0 = note-off.
REQ-011 SHALL have port ev_note, input, NOTE_W bits: note number.
REQ-012 SHALL have port voice_trig, output, NVOICE bits: one-cycle trigger pulse per voice.
REQ-013 SHALL have port voice_gate, output, NVOICE bits: voice held by a note.
REQ-014 SHALL have port voice_note, output, NVOICE*NOTE_W bits: note assigned per voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
REQ-015 SHALL have port voice_busy, output, NVOICE bits: gate high or release count nonzero.
REQ-016 SHALL have port steal, output, 1 bit: one-cycle pulse when a gated voice is stolen.

Function
REQ-017 SHALL implement the FSM states IDLE, SCAN and APPLY; ev_ready SHALL be high only in IDLE.
REQ-018 SHALL capture ev_on and ev_note on acceptance and then transition IDLE->SCAN.
REQ-019 SHALL remain in SCAN for exactly NVOICE cycles, examining voice index 0..NVOICE-1 (one per cycle) using that voice's live state, then go to APPLY for one cycle, then return to IDLE; ev_ready is therefore low for NVOICE+1 cycles per event.
REQ-020 SHALL select the note-on target in this priority order: the gated voice with an equal note (retrigger), else the lowest-index free voice, else the lowest-index releasing voice, else the gated voice with maximum age (lowest index on ties).
REQ-021 SHALL, in APPLY for a note-on, pulse voice_trig[target] high for that cycle only, set gate=1, load note, clear its release count and age, and increment the age of every other gated voice, saturating at 2^AGE_W-1.
REQ-022 SHALL pulse steal in the APPLY cycle only when the fourth priority rule (REQ-020) selected the target.
REQ-023 SHALL, for a note-off, clear the gate of the lowest-index gated voice with an equal note in APPLY and load its release count with REL_CYCLES.
REQ-024 SHALL ignore a note-off with no matching voice: no output change; ev_ready SHALL still return high after APPLY.
REQ-025 SHALL decrement each nonzero release count every cycle, including during SCAN and APPLY, and never below 0.
REQ-026 SHALL not consider, in the current scan, a voice that becomes free after its index has been scanned.
REQ-027 SHALL, when a note-on targets a voice whose count reaches 0 in the same cycle, apply the note-on load, which takes precedence.
REQ-028 SHALL leave voice_note unchanged on note-off and during release.

Reset
REQ-029 SHALL, while rst is high at a rising edge, force state to IDLE and drive ev_ready=0, voice_trig=0, voice_gate=0, voice_busy=0, steal=0, all voice_note=0, and all ages and release counts to 0.
REQ-030 SHALL drive ev_ready high in the first cycle after rst is sampled low.
REQ-031 SHALL abort an in-progress event when reset is asserted mid-SCAN or mid-APPLY, discarding it without a trigger.

Structure
REQ-032 SHALL place the FSM state encoding and the NOTE_W and AGE_W defaults in the shared harbinger_pkg definitions, alongside the other synth constants.
REQ-033 SHALL implement per-voice gate/note/age/release-counter state in a voice_slot sub-module instantiated NVOICE times; voice_alloc keeps the FSM, scan index and candidate registers.

Verification (NVOICE=8, REL_CYCLES=16)
REQ-034 SHALL verify: reset release, then note-on 60 -> ev_ready low for 9 cycles, voice_trig=0x01 for one cycle, voice_gate=0x01, voice 0 note=60.
REQ-035 SHALL verify: note-on 60, 62, 64 -> voices 0, 1, 2 gated; then note-on 62 again -> voice_trig=0x02 (retrigger), no new voice gated.
REQ-036 SHALL verify: note-on 60 then note-off 60 -> gate[0]=0, busy[0]=1 for 16 cycles, then busy[0]=0; note-off 70 with no match -> no output change.
REQ-037 SHALL verify: nine note-ons 40..48 without note-off -> ninth triggers voice 0 (oldest), steal pulses once, voice 0 note=48.
REQ-038 SHALL verify: all 8 voices busy with voice 3 releasing and the rest gated -> new note-on targets voice 3, steal=0.
REQ-039 SHALL verify: rst asserted on the 4th SCAN cycle -> no voice_trig, all outputs 0, ev_ready=1 on the first cycle after rst drops.
